// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider.
//   start       - operation request, master -> slave
//   dividend    - unsigned dividend, master -> slave
//   divisor     - unsigned divisor, master -> slave
//   busy        - iteration in progress, slave -> master
//   done        - one-cycle result-valid pulse, slave -> master
//   quotient    - result quotient, slave -> master
//   remainder   - result remainder, slave -> master
//   div_by_zero - captured divisor was zero, slave -> master
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one shift-subtract-restore step per cycle.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - seq_divider_if slave: start/dividend/divisor in;
//           busy/done/quotient/remainder/div_by_zero out
// A request is accepted in IDLE or DONE; results appear WIDTH+1 cycles after the start
// cycle and are held until the next accepted request completes.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH:0]   r_rem;    // partial remainder, one bit wider than the divisor
  logic [WIDTH-1:0] r_work;   // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_div;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  state_e           w_state;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_work;
  logic [WIDTH-1:0] w_div;
  logic [CntW-1:0]  w_cnt;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_remo;
  logic             w_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // The remainder stays below the divisor between steps, so its top bit is always zero
  // before the shift and can be dropped.
  assign w_shift = {r_rem[WIDTH-1:0], r_work[WIDTH-1]};
  // Wide subtraction: a borrow shows up in the MSB even when w_shift >= 2^WIDTH - 1.
  assign w_trial = w_shift - {1'b0, r_div};

  always_comb begin
    w_state = r_state;
    w_rem   = r_rem;
    w_work  = r_work;
    w_div   = r_div;
    w_cnt   = r_cnt;
    w_quot  = r_quot;
    w_remo  = r_remo;
    w_dbz   = r_dbz;

    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_rem   = '0;
          w_work  = bus.dividend;
          w_div   = bus.divisor;
          w_cnt   = '0;
          w_state = StRun;
        end else begin
          w_state = StIdle;
        end
      end
      StRun: begin
        if (!w_trial[WIDTH]) begin
          w_rem  = w_trial;
          w_work = {r_work[WIDTH-2:0], 1'b1};
        end else begin
          w_rem  = w_shift;
          w_work = {r_work[WIDTH-2:0], 1'b0};
        end
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          // Publish on the same edge as the final step.
          w_state = StDone;
          w_quot  = w_work;
          w_remo  = w_rem[WIDTH-1:0];
          w_dbz   = (r_div == '0);
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_work  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_rem   <= w_rem;
      r_work  <= w_work;
      r_div   <= w_div;
      r_cnt   <= w_cnt;
      r_quot  <= w_quot;
      r_remo  <= w_remo;
      r_dbz   <= w_dbz;
    end
  end

  assign bus.busy        = (r_state == StRun);
  assign bus.done        = (r_state == StDone);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;

endmodule
